pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- PC register stage directly downstream of the next-PC select logic.
- Consumes the 3-bit PC_select code and the candidate target addresses, and produces the fetch PC each cycle.
- Owns mispredict recovery bubbles and a flush pulse toward fetch/decode.
- Sits between next-PC selection and the instruction cache address port.

Parameters:
- PC_W, 16, PC and target width in bits.
- FETCH_INC, 4, sequential increment applied on select 5.
- RESET_PC, 16'h0000, PC value after reset and on select 7.
- RECOV_BUBBLES, 2, cycles fetch_valid is held low after a mispredict redirect; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- PC_select  in  3  next-PC source code: 0 pred_tgt0, 1 pred_tgt1, 2 jump_tgt, 3 pc_recovery, 4 pc_bhndlr, 5 sequential, 6 stall, 7 reset-hold.
- pred_tgt0  in  PC_W  predicted-taken target, first branch slot.
- pred_tgt1  in  PC_W  predicted-taken target, second branch slot.
- jump_tgt  in  PC_W  jump target.
- pc_recovery  in  PC_W  mispredict recovery PC.
- pc_bhndlr  in  PC_W  branch-handler PC (third branch flushed).
- pc  out  PC_W  current fetch PC (registered).
- fetch_valid  out  1  pc is a live fetch address.
- redirect  out  1  one-cycle pulse: pc was loaded from a non-sequential source (selects 0-4) on the previous edge.
- redirect_src  out  3  select code that caused the last redirect; holds until the next redirect.
- flush  out  1  one-cycle pulse after a select-3 load.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, fetch_valid=0, redirect=0, redirect_src=0, flush=0.
  - bubble counter=0, state=BOOT.
- State BOOT:
  - select 7 stays in BOOT with pc=RESET_PC and fetch_valid=0.
  - Any other code moves to RUN with fetch_valid=1 and pc unchanged (RESET_PC), so the first fetch is RESET_PC. The code that caused the exit is otherwise ignored.
- State RUN, per edge:
  - 0/1/2/4: pc ← the corresponding target; redirect=1, redirect_src=code.
  - 5: pc ← pc+FETCH_INC, truncated mod 2^PC_W (wraps, no carry out).
  - 6: pc held; fetch_valid stays 1.
  - 3: pc ← pc_recovery; redirect=1, flush=1, redirect_src=3; fetch_valid=0; counter ← RECOV_BUBBLES; state=RECOVER.
  - 7: pc ← RESET_PC, fetch_valid=0, state=BOOT.
- State RECOVER:
  - pc held, fetch_valid=0, counter decrements each edge.
  - Codes 0,1,2,4,5,6 are ignored.
  - Code 3 restarts recovery: new pc_recovery loaded, flush and redirect pulse again, counter reloaded.
  - Code 7 goes to BOOT.
  - When counter reaches 1 and code is not 3/7: state=RUN, fetch_valid=1 at that edge.
  - Result: exactly RECOV_BUBBLES cycles with fetch_valid=0 after the flush edge.
- redirect and flush are registered pulses lasting exactly one cycle. They are deasserted on every edge that does not set them.
- Priority: rst over everything, then select 7, then select 3, then others.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro PC_GEN_PERF_EN.
- When defined, adds two outputs:
  - stall_cycles[15:0]: counts edges in RUN with select 6.
  - recov_cycles[15:0]: counts edges in RECOVER.
  - Both saturate at 16'hFFFF, clear on rst, and are unaffected by select 7.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan (defaults PC_W=16, FETCH_INC=4, RESET_PC=0, RECOV_BUBBLES=2):
- Boot/sequential: rst 1 cycle, then select 5 for 4 cycles → pc 0,0,4,8,C with fetch_valid 0,1,1,1,1; redirect never asserted.
- Wrap: reach pc=16'hFFFC, apply select 5 → pc=16'h0000, no redirect.
- Redirect sources: select 2 with jump_tgt=16'h0100 → next pc=0100, redirect=1 for one cycle, redirect_src=2; following select 6 ×3 → pc stays 0100, fetch_valid=1.
- Mispredict: at pc=0040, select 3 with pc_recovery=0200 → pc=0200, flush=1 and redirect=1 for one cycle, fetch_valid=0 for exactly 2 cycles. Select 0 with pred_tgt0=0300 during the bubbles is ignored. Then fetch_valid=1 with pc=0200.
- Back-to-back mispredict: second select 3 (pc_recovery=0280) in the first bubble → pc=0280, second flush pulse, 2 fresh bubble cycles.
- Reset mid-recovery: assert rst during RECOVER → pc=0, fetch_valid=0, flush=0, state BOOT. Select 7 held 3 cycles keeps BOOT; with PC_GEN_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC register with boot hold, redirect/flush pulses and mispredict recovery bubbles.
// Optional PC_GEN_PERF_EN adds saturating stall/recovery cycle counters.
module pc_gen #(
  parameter int              PC_W          = 16,
  parameter int              FETCH_INC     = 4,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter int              RECOV_BUBBLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      PC_select,
  input  logic [PC_W-1:0] pred_tgt0,
  input  logic [PC_W-1:0] pred_tgt1,
  input  logic [PC_W-1:0] jump_tgt,
  input  logic [PC_W-1:0] pc_recovery,
  input  logic [PC_W-1:0] pc_bhndlr,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            redirect,
  output logic [2:0]      redirect_src,
  output logic            flush,
  output logic [1:0]      fsm_state
`ifdef PC_GEN_PERF_EN
  ,
  output logic [15:0]     stall_cycles,
  output logic [15:0]     recov_cycles
`endif
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_RUN     = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam logic [2:0] SEL_TGT0  = 3'd0;
  localparam logic [2:0] SEL_TGT1  = 3'd1;
  localparam logic [2:0] SEL_JUMP  = 3'd2;
  localparam logic [2:0] SEL_RECOV = 3'd3;
  localparam logic [2:0] SEL_BHND  = 3'd4;
  localparam logic [2:0] SEL_SEQ   = 3'd5;
  localparam logic [2:0] SEL_RESET = 3'd7;

  state_t     state;
  logic [3:0] bubble_cnt;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_BOOT;
      pc           <= RESET_PC;
      fetch_valid  <= 1'b0;
      redirect     <= 1'b0;
      redirect_src <= 3'd0;
      flush        <= 1'b0;
      bubble_cnt   <= 4'd0;
    end else begin
      redirect <= 1'b0;
      flush    <= 1'b0;
      if (PC_select == SEL_RESET) begin
        state       <= S_BOOT;
        pc          <= RESET_PC;
        fetch_valid <= 1'b0;
        bubble_cnt  <= 4'd0;
      end else if (state == S_BOOT) begin
        // First fetch is RESET_PC; the exiting code itself is not acted on.
        state       <= S_RUN;
        fetch_valid <= 1'b1;
      end else if (PC_select == SEL_RECOV) begin
        state        <= S_RECOVER;
        pc           <= pc_recovery;
        fetch_valid  <= 1'b0;
        redirect     <= 1'b1;
        flush        <= 1'b1;
        redirect_src <= SEL_RECOV;
        bubble_cnt   <= 4'(RECOV_BUBBLES);
      end else if (state == S_RECOVER) begin
        if (bubble_cnt == 4'd1) begin
          state       <= S_RUN;
          fetch_valid <= 1'b1;
          bubble_cnt  <= 4'd0;
        end else begin
          bubble_cnt <= bubble_cnt - 4'd1;
        end
      end else begin
        case (PC_select)
          SEL_TGT0: begin
            pc <= pred_tgt0; redirect <= 1'b1; redirect_src <= PC_select;
          end
          SEL_TGT1: begin
            pc <= pred_tgt1; redirect <= 1'b1; redirect_src <= PC_select;
          end
          SEL_JUMP: begin
            pc <= jump_tgt; redirect <= 1'b1; redirect_src <= PC_select;
          end
          SEL_BHND: begin
            pc <= pc_bhndlr; redirect <= 1'b1; redirect_src <= PC_select;
          end
          SEL_SEQ: pc <= pc + PC_W'(FETCH_INC);
          default: ; // stall: hold pc, stay live
        endcase
      end
    end
  end

`ifdef PC_GEN_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 16'd0;
      recov_cycles <= 16'd0;
    end else begin
      if (state == S_RUN && PC_select == 3'd6 && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (state == S_RECOVER && recov_cycles != 16'hFFFF)
        recov_cycles <= recov_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed plan steps then random selects, checked against a cycle-level reference model.
module tb_pc_gen;
  localparam int          PC_W = 16;
  localparam int          INC  = 4;
  localparam logic [15:0] RPC  = 16'h0000;
  localparam int          NB   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [2:0]      PC_select = 3'd7;
  logic [PC_W-1:0] pred_tgt0 = '0, pred_tgt1 = '0, jump_tgt = '0, pc_recovery = '0, pc_bhndlr = '0;
  logic [PC_W-1:0] pc;
  logic            fetch_valid, redirect, flush;
  logic [2:0]      redirect_src;
  logic [1:0]      fsm_state;
`ifdef PC_GEN_PERF_EN
  logic [15:0]     stall_cycles, recov_cycles;
`endif

  int errors = 0;
  int checks = 0;

  pc_gen #(.PC_W(PC_W), .FETCH_INC(INC), .RESET_PC(RPC), .RECOV_BUBBLES(NB)) dut (
    .clk(clk), .rst(rst), .PC_select(PC_select),
    .pred_tgt0(pred_tgt0), .pred_tgt1(pred_tgt1), .jump_tgt(jump_tgt),
    .pc_recovery(pc_recovery), .pc_bhndlr(pc_bhndlr),
    .pc(pc), .fetch_valid(fetch_valid), .redirect(redirect),
    .redirect_src(redirect_src), .flush(flush), .fsm_state(fsm_state)
`ifdef PC_GEN_PERF_EN
    , .stall_cycles(stall_cycles), .recov_cycles(recov_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: "live" after boot, plus a count of invalid cycles still owed after a flush.
  bit          m_live;
  logic [15:0] m_pc;
  int          m_owed;
  logic        m_redir, m_flush;
  logic [2:0]  m_src;
  int          m_stall, m_recov;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":pc"}, pc, m_pc);
    chk({ctx, ":fetch_valid"}, 16'(fetch_valid), 16'(m_live && m_owed == 0));
    chk({ctx, ":redirect"}, 16'(redirect), 16'(m_redir));
    chk({ctx, ":redirect_src"}, 16'(redirect_src), 16'(m_src));
    chk({ctx, ":flush"}, 16'(flush), 16'(m_flush));
`ifdef PC_GEN_PERF_EN
    chk({ctx, ":stall_cycles"}, stall_cycles, 16'(m_stall));
    chk({ctx, ":recov_cycles"}, recov_cycles, 16'(m_recov));
`endif
  endtask

  task automatic do_reset(input string ctx);
    rst = 1'b1;
    PC_select = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_live = 0; m_pc = RPC; m_owed = 0; m_redir = 0; m_flush = 0; m_src = 0;
    m_stall = 0; m_recov = 0;
    check_all(ctx);
  endtask

  // Drive one select; val lands on the target the select would use, other targets get noise.
  task automatic step(input logic [2:0] sel, input logic [15:0] val, input string ctx);
    logic [15:0] tgt;
    PC_select   = sel;
    pred_tgt0   = 16'($urandom); pred_tgt1 = 16'($urandom); jump_tgt = 16'($urandom);
    pc_recovery = 16'($urandom); pc_bhndlr = 16'($urandom);
    case (sel)
      3'd0: pred_tgt0 = val;
      3'd1: pred_tgt1 = val;
      3'd2: jump_tgt = val;
      3'd3: pc_recovery = val;
      3'd4: pc_bhndlr = val;
      default: ;
    endcase
    tgt = (sel == 0) ? pred_tgt0 : (sel == 1) ? pred_tgt1 : (sel == 2) ? jump_tgt : pc_bhndlr;
    m_redir = 0; m_flush = 0;
    if (m_live && m_owed > 0 && m_recov < 65535) m_recov++;
    if (m_live && m_owed == 0 && sel == 3'd6 && m_stall < 65535) m_stall++;
    if (sel == 3'd7) begin
      m_live = 0; m_pc = RPC; m_owed = 0;
    end else if (!m_live) begin
      m_live = 1;
    end else if (sel == 3'd3) begin
      m_pc = pc_recovery; m_owed = NB; m_redir = 1; m_flush = 1; m_src = 3;
    end else if (m_owed > 0) begin
      m_owed--;
    end else if (sel == 3'd5) begin
      m_pc = m_pc + 16'(INC);
    end else if (sel != 3'd6) begin
      m_pc = tgt; m_redir = 1; m_src = sel;
    end
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  initial begin
    // Boot and sequential fetch
    do_reset("reset");
    for (int i = 0; i < 4; i++) step(3'd5, 16'h0, "boot_seq");
    chk("boot_seq_end_pc", pc, 16'h000C);

    // Wrap
    step(3'd2, 16'hFFFC, "to_fffc");
    step(3'd5, 16'h0, "wrap");
    chk("wrap_pc", pc, 16'h0000);

    // Jump then stall
    step(3'd2, 16'h0100, "jump");
    chk("jump_src", 16'(redirect_src), 16'h2);
    for (int i = 0; i < 3; i++) step(3'd6, 16'h0, "stall");
    chk("stall_pc", pc, 16'h0100);

    // Other redirect sources
    step(3'd0, 16'h1230, "tgt0");
    step(3'd1, 16'h2340, "tgt1");
    step(3'd4, 16'h3450, "bhndlr");
    chk("bhndlr_src", 16'(redirect_src), 16'h4);

    // Mispredict with ignored predicted target during the bubbles
    step(3'd2, 16'h0040, "to_0040");
    step(3'd3, 16'h0200, "mispredict");
    chk("mispredict_flush", 16'(flush), 16'h1);
    step(3'd0, 16'h0300, "bubble1");
    chk("bubble1_valid", 16'(fetch_valid), 16'h0);
    step(3'd0, 16'h0300, "bubble2");
    chk("recovered_pc", pc, 16'h0200);
    chk("recovered_valid", 16'(fetch_valid), 16'h1);
    step(3'd5, 16'h0, "post_recover");

    // Back-to-back mispredict
    step(3'd3, 16'h0200, "b2b_first");
    step(3'd3, 16'h0280, "b2b_second");
    chk("b2b_pc", pc, 16'h0280);
    step(3'd6, 16'h0, "b2b_bubble1");
    step(3'd6, 16'h0, "b2b_bubble2");
    chk("b2b_valid", 16'(fetch_valid), 16'h1);

    // Reset mid-recovery, then hold in boot
    step(3'd3, 16'h0500, "pre_reset_recov");
    do_reset("reset_mid_recov");
    for (int i = 0; i < 3; i++) step(3'd7, 16'h0, "boot_hold");
    chk("boot_hold_valid", 16'(fetch_valid), 16'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset("rand_reset");
      else if (r < 6) step(3'd7, 16'h0, "rand");
      else if (r < 16) step(3'd3, 16'($urandom), "rand");
      else if (r < 50) step(3'd5, 16'h0, "rand");
      else if (r < 62) step(3'd6, 16'h0, "rand");
      else step(3'($urandom_range(0, 2)) + ((r & 1) != 0 ? 3'd0 : 3'd0), 16'($urandom), "rand");
      if (r >= 95) step(3'd4, 16'($urandom), "rand_bh");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
